// File: rtl/legv8_pkg.sv
// Shared fetch-path types: address/instruction widths and the buffered fetch entry.
package legv8_pkg;
  localparam int ADDR_W      = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush, occupancy count and flags.
// The head entry comes straight out of the storage registers.
module fetch_fifo
  import legv8_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A flush wins over both push and pop in the same cycle.
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // State registers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited in-order imem requests,
// buffers returned words with their PC and drops wrong-path responses after a redirect.
module instruction_fetch
  import legv8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic              req_en_q;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic              gnt_fire, push, pop;
  logic [ADDR_W-1:0] redirect_aligned;
  fetch_entry_t      push_entry, head;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign gnt_fire         = imem_req & imem_gnt;
  // Credit counts only registered state, so decode's ready never reaches imem_req.
  // req_en_q keeps the request low while in reset and until the first edge after it.
  assign imem_req   = req_en_q & (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_C);
  assign imem_addr  = fetch_pc_q;
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rdata};
  assign pop        = if_valid & if_ready;
  assign if_valid   = ~fifo_empty;
  assign if_pc      = head.pc;
  assign if_instr   = head.instr;

  // PC advance, in-flight tracking and wrong-path drop accounting.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid);
    drop_d        = drop_q;
    push          = 1'b0;
    if (gnt_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      drop_d     = outstanding_d;
    end else if (imem_rvalid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - CW'(1);
      end else begin
        push     = 1'b1;
        rsp_pc_d = rsp_pc_q + ADDR_W'(INSTR_BYTES);
      end
    end
  end

  // Control registers.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      req_en_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      req_en_q      <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (Reset_L),
    .flush (redirect_valid),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The credit rule must never let a response arrive into a full buffer.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!Reset_L)
    !(fifo_full && push && !pop && !redirect_valid));
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a fixed-latency in-order memory model.
module tb_instruction_fetch;
  import legv8_pkg::*;

  logic               CLK = 1'b0;
  logic               Reset_L = 1'b1;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt = 1'b0;
  logic               imem_rvalid = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               if_valid;
  logic               if_ready = 1'b0;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;

  typedef struct { logic [ADDR_W-1:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  logic [63:0] got_pc[$];
  logic [63:0] got_ins[$];
  int          lat = 1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  instruction_fetch dut (
    .CLK(CLK), .Reset_L(Reset_L), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 CLK = ~CLK;

  // Memory: grants every request, answers in order after lat cycles with addr>>2.
  initial forever begin
    @(posedge CLK); #1;
    cyc++;
    if (!Reset_L) begin
      mq.delete();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    end else begin
      imem_rvalid = 1'b0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mreq_t r;
        r = mq.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = INSTR_W'(r.addr >> 2);
      end
      imem_gnt = 1'b1;
      if (imem_req) mq.push_back('{addr: imem_addr, due: cyc + lat});
    end
  end

  // Decode side: log every accepted instruction (pops in a redirect cycle are void).
  initial forever begin
    @(negedge CLK);
    if (Reset_L && if_valid && if_ready && !redirect_valid) begin
      got_pc.push_back(if_pc);
      got_ins.push_back(64'(if_instr));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] gp(input int i);
    return (i < got_pc.size()) ? got_pc[i] : '1;
  endfunction

  function automatic logic [63:0] gi(input int i);
    return (i < got_ins.size()) ? got_ins[i] : '1;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 8) begin tick(); n++; end
    check("req_seen", 64'(imem_req), 64'd1);
  endtask

  task automatic do_reset();
    Reset_L = 1'b0;
    redirect_valid = 1'b0;
    tick();
    got_pc.delete(); got_ins.delete();
    @(negedge CLK);
    Reset_L = 1'b1;
    tick();
    wait_req();
  endtask

  initial begin
    // Reset state, no clock edge yet.
    #1 Reset_L = 1'b0;
    #2;
    check("rst_req",   64'(imem_req), 64'd0);
    check("rst_valid", 64'(if_valid), 64'd0);
    check("rst_pc",    if_pc, 64'd0);
    check("rst_instr", 64'(if_instr), 64'd0);
    check("rst_addr",  imem_addr, 64'd0);

    // Sequential fetch, 1-cycle memory, decode always ready.
    lat = 1; if_ready = 1'b1;
    do_reset();
    check("seq_addr0", imem_addr, 64'd0);
    tick();
    check("seq_lat_n1", 64'(if_valid), 64'd0);
    tick();
    check("seq_lat_n2", 64'(if_valid), 64'd1);
    check("seq_pc0", if_pc, 64'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("seq_pc", if_valid ? if_pc : 64'hdead, 64'(4 * i));
      check("seq_instr", 64'(if_instr), 64'(i));
    end

    // Backpressure: credit fills the buffer, then drains in order.
    if_ready = 1'b0;
    do_reset();
    tick(10);
    check("bp_req",   64'(imem_req), 64'd0);
    check("bp_valid", 64'(if_valid), 64'd1);
    check("bp_head",  if_pc, 64'd0);
    check("bp_addr",  imem_addr, 64'h10);
    if_ready = 1'b1;
    tick(12);
    for (int i = 0; i < 6; i++) begin
      check("bp_pc", gp(i), 64'(4 * i));
      check("bp_instr", gi(i), 64'(i));
    end

    // Wrong-path flush with 3-cycle memory and two requests in flight.
    lat = 3; if_ready = 1'b1;
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    check("wp_drop", 64'(dut.drop_q), 64'd2);
    check("wp_addr", imem_addr, 64'h2000);
    tick(12);
    check("wp_pc0",  gp(0), 64'h2000);
    check("wp_ins0", gi(0), 64'h800);
    check("wp_pc1",  gp(1), 64'h2004);

    // Redirect in the same cycle as a grant and a response.
    lat = 2;
    do_reset();
    tick(2);
    check("co_setup", {61'd0, imem_rvalid, imem_req, imem_gnt}, 64'd7);
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    check("co_drop", 64'(dut.drop_q), 64'd2);
    tick(10);
    check("co_pc0",  gp(0), 64'h3000);
    check("co_ins0", gi(0), 64'hc00);
    check("co_pc1",  gp(1), 64'h3004);

    // Unaligned redirect while the buffer holds valid data.
    lat = 1;
    do_reset();
    tick(3);
    check("ua_pre_valid", 64'(if_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h1003;
    tick();
    redirect_valid = 1'b0;
    check("ua_valid_drop", 64'(if_valid), 64'd0);
    check("ua_addr", imem_addr, 64'h1000);
    got_pc.delete(); got_ins.delete();
    tick(6);
    check("ua_pc0",  gp(0), 64'h1000);
    check("ua_ins0", gi(0), 64'h400);
    check("ua_pc1",  gp(1), 64'h1004);

    // Asynchronous reset mid-cycle with a full buffer.
    if_ready = 1'b0;
    do_reset();
    tick(10);
    check("ar_full_valid", 64'(if_valid), 64'd1);
    @(posedge CLK); #3;
    Reset_L = 1'b0;
    #1;
    check("ar_valid", 64'(if_valid), 64'd0);
    check("ar_req",   64'(imem_req), 64'd0);
    check("ar_addr",  imem_addr, 64'd0);
    check("ar_out",   64'(dut.outstanding_q), 64'd0);
    check("ar_drop",  64'(dut.drop_q), 64'd0);
    got_pc.delete(); got_ins.delete();
    @(negedge CLK);
    Reset_L = 1'b1; if_ready = 1'b1;
    tick();
    wait_req();
    check("ar_first_addr", imem_addr, 64'd0);
    tick(5);
    check("ar_pc0", gp(0), 64'd0);
    check("ar_pc1", gp(1), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage that owns the architectural PC register and feeds the decode stage. It issues in-order requests to instruction memory, buffers returned words with their PC in a small FIFO, and presents {pc, instr} to decode over a valid/ready handshake. It takes redirects from the NextPC logic (taken branch or unconditional branch target) and discards any wrong-path fetches.

Parameters:
ADDR_W, 64, PC / address width
INSTR_W, 32, instruction width
RESET_PC, 64'h0, fetch address after reset
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)

Ports:
CLK  in  1  clock, rising edge
Reset_L  in  1  asynchronous, active-low reset
redirect_valid  in  1  NextPC logic requests a non-sequential PC
redirect_pc  in  ADDR_W  redirect target (NextPC)
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address, low 2 bits always 0
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid, in request order, latency >=1
imem_rdata  in  INSTR_W  read data
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts
if_instr  out  INSTR_W  fetched instruction
if_pc  out  ADDR_W  PC of if_instr (CurrentPC for decode/NextPC logic)

Behaviour:
- Reset (Reset_L=0, takes effect immediately, no clock needed): fetch_pc=RESET_PC, outstanding=0, drop=0, FIFO empty; outputs are imem_req=0, if_valid=0, if_instr=0, if_pc=0. imem_addr equals fetch_pc.
- Credit rule: imem_req = (outstanding + fifo_count < FIFO_DEPTH). This uses registered counts only, so there is no combinational path from if_ready.
- Request: imem_addr = fetch_pc. Req and addr hold stable until imem_gnt, except on a redirect.
- On imem_gnt: fetch_pc += 4 (wraps modulo 2^ADDR_W); outstanding += 1.
- On imem_rvalid: outstanding -= 1.
  - If drop > 0: drop -= 1 and the word is discarded.
  - Otherwise, push {pc, rdata}. The pc comes from an in-order pc queue, or equivalently a response-pc counter advanced by 4 per accepted response.
- Pop when if_valid & if_ready. Push and pop in the same cycle are allowed at any occupancy, including full (a push while full cannot occur, by the credit rule).
- Latency: imem_gnt at cycle N with 1-cycle memory gives rvalid at N+1 and if_valid at N+2 (registered FIFO output). With FIFO_DEPTH>=3 and 1-cycle memory, sustained throughput is 1 instr/cycle.
- Redirect (redirect_valid=1 at an edge):
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}, so low bits are forced to 0.
  - The FIFO is flushed, and a pop in the same cycle is ignored.
  - drop <= outstanding + gnt - rvalid, i.e. every request still in flight after this edge is discarded.
  - A request granted in the redirect cycle used the old address and is counted in drop.
  - A response arriving in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins, and drop is recomputed each time.
- if_valid deasserts on the edge that applies a redirect. The first post-redirect if_pc equals the aligned redirect_pc.
- Outputs hold while if_valid=1 and if_ready=0.
- Counter widths: outstanding and drop are $clog2(FIFO_DEPTH)+1 bits. Neither can exceed FIFO_DEPTH.

Decomposition:
- Shared package legv8_pkg: ADDR_W, INSTR_W, INSTR_BYTES=4, and the fetch_entry_t struct {pc, instr}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t with flush, count output, and full/empty flags.
- Control (PC register, credit, drop counter) stays in instruction_fetch.

Test Plan:
- Sequential fetch: release reset, 1-cycle memory, if_ready=1, imem_rdata=addr>>2 → if_pc=0,4,8,C... on consecutive cycles; first if_valid 2 cycles after the first gnt; no bubbles.
- Backpressure: if_ready=0 for 10 cycles → 4 entries held, imem_req=0 once credit is exhausted; if_ready=1 → pc 0..C drained in order, fetching resumes at 0x10, no loss or duplication.
- Wrong-path flush: 3-cycle memory, 2 requests outstanding, redirect_pc=0x2000 → both late responses dropped; next if_pc=0x2000, then 0x2004.
- Redirect coinciding with gnt and rvalid in the same cycle → that response and the granted request are both discarded; drop reaches 0 before any 0x3000 data is pushed; first if_pc=0x3000.
- Unaligned redirect_pc=0x1003 → imem_addr=0x1000, if_pc=0x1000.
- Reset between clock edges while the FIFO is full → if_valid, imem_req and counters clear immediately; after release the first request is at RESET_PC.
